// File: rtl/deserializer_1to64_serdes.sv
// rtl/deserializer_1to64_serdes.sv - 1:64 serial-to-parallel deserializer with two-word output FIFO (optional parity: DESER_PARITY_EN)
module deserializer_1to64_serdes (
  input  logic        clk_serial,
  input  logic        rst,
  input  logic        serial_in,
  input  logic        serial_valid,
  input  logic        sof,
  output logic [63:0] data_out,
  output logic        valid_out,
  input  logic        ready_in,
  output logic        overflow,
  output logic        frame_err,
  output logic        parity_err
);

`ifdef DESER_PARITY_EN
  localparam logic [6:0] LAST_IDX = 7'd64;
`else
  localparam logic [6:0] LAST_IDX = 7'd63;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic [6:0]  bit_count_q, bit_count_d;
  logic [63:0] shift_q, shift_d;
  logic [63:0] shifted;
  logic        word_done;
  logic        done_par;
  logic        frame_err_q, frame_err_d;
  logic        overflow_q, overflow_d;
  logic [63:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic        par0_q, par0_d, par1_q, par1_d;
  logic        full0_q, full0_d, full1_q, full1_d;
`ifdef DESER_PARITY_EN
  logic        par_q, par_d;
`endif

  // The parity bit (index 64) is not shifted into the data word.
  assign shifted = (bit_count_q < 7'd64) ? {shift_q[62:0], serial_in} : shift_q;

  // Frame assembly: IDLE waits for sof, SHIFT counts bits and restarts on a mid-word sof.
  always_comb begin
    state_d     = state_q;
    bit_count_d = bit_count_q;
    shift_d     = shift_q;
    word_done   = 1'b0;
    frame_err_d = 1'b0;
    done_par    = 1'b0;
`ifdef DESER_PARITY_EN
    par_d       = par_q;
    done_par    = par_q ^ serial_in;
`endif
    if (serial_valid) begin
      case (state_q)
        IDLE: begin
          if (sof) begin
            state_d     = SHIFT;
            shift_d     = {63'b0, serial_in};
            bit_count_d = 7'd1;
`ifdef DESER_PARITY_EN
            par_d       = serial_in;
`endif
          end
        end
        SHIFT: begin
          if (sof && (bit_count_q != 7'd0)) begin
            frame_err_d = 1'b1;
            shift_d     = {63'b0, serial_in};
            bit_count_d = 7'd1;
`ifdef DESER_PARITY_EN
            par_d       = serial_in;
`endif
          end else begin
            shift_d = shifted;
`ifdef DESER_PARITY_EN
            par_d   = par_q ^ serial_in;
`endif
            if (bit_count_q == LAST_IDX) begin
              word_done   = 1'b1;
              bit_count_d = 7'd0;
`ifdef DESER_PARITY_EN
              par_d       = 1'b0;
`endif
            end else begin
              bit_count_d = bit_count_q + 7'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Two-entry FIFO: pop first so a simultaneous pop frees room for the completing word.
  always_comb begin
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    par0_d     = par0_q;
    par1_d     = par1_q;
    full0_d    = full0_q;
    full1_d    = full1_q;
    overflow_d = 1'b0;
    if (full0_q && ready_in) begin
      buf0_d  = buf1_q;
      par0_d  = par1_q;
      full0_d = full1_q;
      buf1_d  = 64'b0;
      par1_d  = 1'b0;
      full1_d = 1'b0;
    end
    if (word_done) begin
      if (!full0_d) begin
        buf0_d  = shifted;
        par0_d  = done_par;
        full0_d = 1'b1;
      end else if (!full1_d) begin
        buf1_d  = shifted;
        par1_d  = done_par;
        full1_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // State and buffer registers; reset discards everything.
  always_ff @(posedge clk_serial or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_count_q <= 7'd0;
      shift_q     <= 64'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      buf0_q      <= 64'b0;
      buf1_q      <= 64'b0;
      par0_q      <= 1'b0;
      par1_q      <= 1'b0;
      full0_q     <= 1'b0;
      full1_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      par0_q      <= par0_d;
      par1_q      <= par1_d;
      full0_q     <= full0_d;
      full1_q     <= full1_d;
    end
  end

`ifdef DESER_PARITY_EN
  // Running XOR of the frame bits received so far.
  always_ff @(posedge clk_serial or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`endif

  assign data_out   = buf0_q;
  assign valid_out  = full0_q;
  assign parity_err = par0_q;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_deserializer_1to64_serdes.sv
// tb/tb_deserializer_1to64_serdes.sv - scoreboard testbench for deserializer_1to64_serdes
module tb_deserializer_1to64_serdes;

  logic        clk;
  logic        rst;
  logic        serial_in;
  logic        serial_valid;
  logic        sof;
  logic [63:0] data_out;
  logic        valid_out;
  logic        ready_in;
  logic        overflow;
  logic        frame_err;
  logic        parity_err;

  typedef struct packed {
    logic [63:0] d;
    logic        p;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ovf_cnt = 0;
  int   ferr_cnt = 0;

  deserializer_1to64_serdes dut (
    .clk_serial  (clk),
    .rst         (rst),
    .serial_in   (serial_in),
    .serial_valid(serial_valid),
    .sof         (sof),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .ready_in    (ready_in),
    .overflow    (overflow),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts pulses and compares every transferred word against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (overflow)  ovf_cnt++;
      if (frame_err) ferr_cnt++;
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", data_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("word", {63'b0, data_out, parity_err}, {63'b0, e.d, e.p});
        end
      end
    end
  end

  task automatic drive(input logic b, input logic s, input logic v);
    serial_in    = b;
    sof          = s;
    serial_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [63:0] w, input bit with_sof, input bit toggle, input logic pbit);
    for (int i = 63; i >= 0; i--) begin
      if (toggle) drive(~w[i], 1'b1, 1'b0);
      drive(w[i], with_sof && (i == 63), 1'b1);
    end
`ifdef DESER_PARITY_EN
    if (toggle) drive(1'b0, 1'b1, 1'b0);
    drive(pbit, 1'b0, 1'b1);
`else
    if (pbit === 1'bx) $display("pbit unknown");
`endif
    serial_valid = 1'b0;
    sof          = 1'b0;
  endtask

  task automatic push(input logic [63:0] d, input logic p);
    exp_t e;
    e.d = d;
    e.p = p;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; serial_in = 1'b0; serial_valid = 1'b0; sof = 1'b0; ready_in = 1'b0;
    #3;
    check("reset_outputs", {data_out, valid_out, overflow, frame_err, parity_err}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // single frame, ready high
    ready_in = 1'b1;
    push(64'hDEADBEEF_01234567, 1'b0);
    send_frame(64'hDEADBEEF_01234567, 1'b1, 1'b0, ^64'hDEADBEEF_01234567);
    check("latency_valid", valid_out, 1);
    check("latency_data", data_out, 64'hDEADBEEF_01234567);
    idle(1);
    check("single_cycle_valid", valid_out, 0);
    drain("drain_t1");

    // back-to-back frames into a stalled FIFO
    ready_in = 1'b0;
    push(64'hA5A5A5A5_A5A5A5A5, 1'b0);
    push(64'h0F0F0F0F_0F0F0F0F, 1'b0);
    send_frame(64'hA5A5A5A5_A5A5A5A5, 1'b1, 1'b0, 1'b0);
    send_frame(64'h0F0F0F0F_0F0F0F0F, 1'b0, 1'b0, 1'b0);
    send_frame(64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("stall_valid", valid_out, 1);
    check("stall_data_held", data_out, 64'hA5A5A5A5_A5A5A5A5);
    check("overflow_once", ovf_cnt, 1);
    ready_in = 1'b1;
    drain("drain_t2");
    idle(2);
    check("empty_after_drain", valid_out, 0);

    // sof after 20 bits
    for (int i = 0; i < 20; i++) drive(i[0], i == 0, 1'b1);
    push(64'h01234567_89ABCDEF, 1'b0);
    send_frame(64'h01234567_89ABCDEF, 1'b1, 1'b0, ^64'h01234567_89ABCDEF);
    idle(3);
    check("frame_err_once", ferr_cnt, 1);
    drain("drain_t3");

    // serial_valid toggling
    ready_in = 1'b0;
    push(64'h80000000_00000001, 1'b0);
    send_frame(64'h80000000_00000001, 1'b1, 1'b1, 1'b0);
    check("toggle_valid", valid_out, 1);
    check("toggle_data", data_out, 64'h80000000_00000001);
    ready_in = 1'b1;
    drain("drain_t4");

    // reset mid-frame with a word buffered
    ready_in = 1'b0;
    send_frame(64'h11223344_55667788, 1'b1, 1'b0, ^64'h11223344_55667788);
    for (int i = 0; i < 40; i++) drive(i[1], 1'b0, 1'b1);
    serial_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {data_out, valid_out, overflow, frame_err, parity_err}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ready_in = 1'b1;
    send_frame(64'h55555555_AAAAAAAA, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("no_capture_without_sof", valid_out, 0);
    push(64'hCAFEF00D_12345678, 1'b0);
    send_frame(64'hCAFEF00D_12345678, 1'b1, 1'b0, ^64'hCAFEF00D_12345678);
    drain("drain_t5");

`ifdef DESER_PARITY_EN
    ready_in = 1'b0;
    push(64'h1, 1'b1);
    push(64'h1, 1'b0);
    send_frame(64'h1, 1'b1, 1'b0, 1'b0);
    check("parity_bad", parity_err, 1);
    send_frame(64'h1, 1'b0, 1'b0, 1'b1);
    ready_in = 1'b1;
    drain("drain_t6");
`endif

    idle(3);
    check("overflow_total", ovf_cnt, 1);
    check("frame_err_total", ferr_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
